// File: rtl/ooo_types_pkg.sv
// Shared types for the out-of-order core: ROB tag and checkpoint id widths
// plus the default sizing used by rob_tag_ring.
package ooo_types;

  localparam int DEF_ROB_DEPTH = 16;
  localparam int DEF_ALLOC_W   = 2;
  localparam int DEF_COMMIT_W  = 2;
  localparam int DEF_NUM_CKPT  = 4;

  localparam int ROB_BITS  = $clog2(DEF_ROB_DEPTH);
  localparam int CKPT_BITS = $clog2(DEF_NUM_CKPT);

  typedef logic [ROB_BITS-1:0]  rob_tag_t;
  typedef logic [ROB_BITS:0]    rob_ptr_t;
  typedef logic [CKPT_BITS-1:0] ckpt_id_t;

endpackage

// File: rtl/rob_tag_ring_if.sv
// Dispatch/commit-facing bundle of the ROB tag manager.
// The master side drives requests; the slave side is the tag ring.
interface rob_tag_ring_if #(
  parameter int ROB_DEPTH = 16,
  parameter int ALLOC_W   = 2,
  parameter int COMMIT_W  = 2,
  parameter int NUM_CKPT  = 4
);
  localparam int TAG_W  = $clog2(ROB_DEPTH);
  localparam int CKPT_W = $clog2(NUM_CKPT);
  localparam int ACNT_W = $clog2(ALLOC_W + 1);
  localparam int CCNT_W = $clog2(COMMIT_W + 1);

  logic [ACNT_W-1:0]             alloc_cnt;
  logic                          alloc_ok;
  logic [ALLOC_W-1:0][TAG_W-1:0] alloc_tag;
  logic [CCNT_W-1:0]             commit_cnt;
  logic                          ckpt_req;
  logic                          ckpt_ok;
  logic [CKPT_W-1:0]             ckpt_id;
  logic                          ckpt_release;
  logic                          restore_en;
  logic [CKPT_W-1:0]             restore_id;
  logic [TAG_W-1:0]              head_tag;
  logic [TAG_W:0]                count;
  logic                          full;
  logic                          empty;
  logic                          ckpt_full;

  modport master (
    output alloc_cnt, commit_cnt, ckpt_req, ckpt_release, restore_en, restore_id,
    input  alloc_ok, alloc_tag, ckpt_ok, ckpt_id, head_tag, count, full, empty, ckpt_full
  );

  modport slave (
    input  alloc_cnt, commit_cnt, ckpt_req, ckpt_release, restore_en, restore_id,
    output alloc_ok, alloc_tag, ckpt_ok, ckpt_id, head_tag, count, full, empty, ckpt_full
  );

endinterface

// File: rtl/rob_tag_ring_chk.sv
// Protocol checks on the tag ring's inputs: over-commit, release of an empty
// checkpoint FIFO, and restore to a checkpoint that is not live.
module rob_tag_ring_chk #(
  parameter int PTR_W  = 5,
  parameter int CCNT_W = 2
) (
  input logic              clk,
  input logic              rst,
  input logic [CCNT_W-1:0] commit_cnt,
  input logic [PTR_W-1:0]  count,
  input logic              ckpt_release,
  input logic              ckpt_empty,
  input logic              restore_en,
  input logic              restore_live
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (PTR_W'(commit_cnt) <= count)
        else $error("rob_tag_ring: commit_cnt %0d exceeds occupancy %0d", commit_cnt, count);
      assert (!(ckpt_release && ckpt_empty))
        else $error("rob_tag_ring: ckpt_release with no live checkpoint");
      assert (!(restore_en && !restore_live))
        else $error("rob_tag_ring: restore_en names a checkpoint that is not live");
    end
  end

endmodule

// File: rtl/rob_tag_ring_ckpt_fifo.sv
// Circular FIFO of saved pointers: push at tail, pop at head, and truncate so
// that a given live index becomes the youngest entry.
module ckpt_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       trunc_en,
  input  logic [$clog2(DEPTH)-1:0]   trunc_idx,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH)-1:0]   tail_idx,
  output logic                       full,
  output logic                       empty,
  output logic                       idx_live
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] used_s, offset_s;
  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [WIDTH-1:0] slot_d [DEPTH];

  assign used_s   = tail_q - head_q;
  // Distance of trunc_idx from the oldest entry; it is live when inside the used span.
  assign offset_s = {1'b0, trunc_idx - head_q[IDX_W-1:0]};
  assign idx_live = offset_s < used_s;
  assign full     = used_s == PTR_W'(DEPTH);
  assign empty    = used_s == '0;
  assign rd_data  = slot_q[trunc_idx];
  assign tail_idx = tail_q[IDX_W-1:0];

  always_comb begin
    head_d = pop ? head_q + PTR_W'(1) : head_q;
    slot_d = slot_q;
    if (trunc_en) begin
      // Rebuild the tail from the head so the wrap bit stays consistent.
      tail_d = head_q + offset_s + PTR_W'(1);
    end else if (push) begin
      slot_d[tail_q[IDX_W-1:0]] = push_data;
      tail_d = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

endmodule

// File: rtl/rob_tag_ring.sv
// ROB tag manager: allocates consecutive tags at the tail, retires from the
// head, and rewinds the tail to branch checkpoints on mispredict.
module rob_tag_ring
  import ooo_types::*;
#(
  parameter int ROB_DEPTH = DEF_ROB_DEPTH,
  parameter int ALLOC_W   = DEF_ALLOC_W,
  parameter int COMMIT_W  = DEF_COMMIT_W,
  parameter int NUM_CKPT  = DEF_NUM_CKPT
) (
  input logic            clk,
  input logic            rst,
  rob_tag_ring_if.slave  bus
);
  localparam int TAG_W  = $clog2(ROB_DEPTH);
  localparam int PTR_W  = TAG_W + 1;
  localparam int CKPT_W = $clog2(NUM_CKPT);
  localparam int CCNT_W = $clog2(COMMIT_W + 1);

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]  count_s, tail_post_s, slot_rd_s;
  logic              alloc_ok_s, ckpt_ok_s;
  logic              ck_full_s, ck_empty_s, restore_live_s;
  logic [CKPT_W-1:0] ck_tail_idx_s;

  assign count_s = tail_q - head_q;

  // Free space uses this cycle's count only; a same-cycle commit does not help.
  always_comb begin
    if (bus.restore_en) begin
      alloc_ok_s = 1'b0;
    end else begin
      alloc_ok_s = (PTR_W'(ROB_DEPTH) - count_s) >= PTR_W'(bus.alloc_cnt);
    end
  end

  assign tail_post_s = alloc_ok_s ? tail_q + PTR_W'(bus.alloc_cnt) : tail_q;
  assign ckpt_ok_s   = bus.ckpt_req && !ck_full_s && !bus.restore_en;

  always_comb begin
    head_d = head_q + PTR_W'(bus.commit_cnt);
    if (bus.restore_en) begin
      tail_d = slot_rd_s;
    end else begin
      tail_d = tail_post_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Checkpoints save the post-allocation tail so the branch keeps its own tag.
  ckpt_fifo #(
    .WIDTH (PTR_W),
    .DEPTH (NUM_CKPT)
  ) u_ckpt_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ckpt_ok_s),
    .push_data (tail_post_s),
    .pop       (bus.ckpt_release),
    .trunc_en  (bus.restore_en),
    .trunc_idx (bus.restore_id),
    .rd_data   (slot_rd_s),
    .tail_idx  (ck_tail_idx_s),
    .full      (ck_full_s),
    .empty     (ck_empty_s),
    .idx_live  (restore_live_s)
  );

  always_comb begin
    bus.alloc_tag = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      bus.alloc_tag[i] = tail_q[TAG_W-1:0] + TAG_W'(i);
    end
  end

  assign bus.alloc_ok  = alloc_ok_s;
  assign bus.ckpt_ok   = ckpt_ok_s;
  assign bus.ckpt_id   = ck_tail_idx_s;
  assign bus.head_tag  = head_q[TAG_W-1:0];
  assign bus.count     = count_s;
  assign bus.full      = count_s == PTR_W'(ROB_DEPTH);
  assign bus.empty     = count_s == '0;
  assign bus.ckpt_full = ck_full_s;

  rob_tag_ring_chk #(
    .PTR_W  (PTR_W),
    .CCNT_W (CCNT_W)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .commit_cnt   (bus.commit_cnt),
    .count        (count_s),
    .ckpt_release (bus.ckpt_release),
    .ckpt_empty   (ck_empty_s),
    .restore_en   (bus.restore_en),
    .restore_live (restore_live_s)
  );

endmodule

// File: tb/tb_rob_tag_ring.sv
// Bench for rob_tag_ring: directed scenarios then random legal traffic, checked
// against an unbounded-counter model with a queue of live checkpoints.
module tb_rob_tag_ring;
  import ooo_types::*;

  localparam int DEPTH = 16;
  localparam int AW    = 2;
  localparam int CW    = 2;
  localparam int NCK   = 4;

  typedef struct {
    int id;
    int saved;
  } ck_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rob_tag_ring_if #(.ROB_DEPTH(DEPTH), .ALLOC_W(AW), .COMMIT_W(CW), .NUM_CKPT(NCK)) bus ();

  rob_tag_ring #(.ROB_DEPTH(DEPTH), .ALLOC_W(AW), .COMMIT_W(CW), .NUM_CKPT(NCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: head/tail as ever-increasing tag counts, checkpoints oldest-first.
  int  mhead, mtail, next_id;
  ck_t ckq[$];
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("count", 32'(bus.count), 32'(mtail - mhead));
    chk("head_tag", 32'(bus.head_tag), 32'(mhead % DEPTH));
    chk("full", 32'(bus.full), 32'((mtail - mhead) == DEPTH));
    chk("empty", 32'(bus.empty), 32'((mtail - mhead) == 0));
    chk("ckpt_full", 32'(bus.ckpt_full), 32'(ckq.size() == NCK));
  endtask

  task automatic idle_inputs();
    bus.alloc_cnt    = '0;
    bus.commit_cnt   = '0;
    bus.ckpt_req     = 1'b0;
    bus.ckpt_release = 1'b0;
    bus.restore_en   = 1'b0;
    bus.restore_id   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    mhead = 0;
    mtail = 0;
    next_id = 0;
    ckq.delete();
    check_state();
  endtask

  task automatic cycle(input int ac, input int cc, input bit creq, input bit crel,
                       input bit ren, input int rid);
    bit eaok, ecok;
    int k;
    bus.alloc_cnt    = 2'(ac);
    bus.commit_cnt   = 2'(cc);
    bus.ckpt_req     = creq;
    bus.ckpt_release = crel;
    bus.restore_en   = ren;
    bus.restore_id   = 2'(rid);
    #1;
    eaok = !ren && ((DEPTH - (mtail - mhead)) >= ac);
    ecok = creq && (ckq.size() < NCK) && !ren;
    chk("alloc_ok", 32'(bus.alloc_ok), 32'(eaok));
    chk("ckpt_ok", 32'(bus.ckpt_ok), 32'(ecok));
    if (ecok) chk("ckpt_id", 32'(bus.ckpt_id), 32'(next_id));
    for (int i = 0; i < AW; i++) chk("alloc_tag", 32'(bus.alloc_tag[i]), 32'((mtail + i) % DEPTH));
    @(posedge clk);
    if (ren) begin
      k = -1;
      foreach (ckq[j]) if (ckq[j].id == rid) k = j;
      if (k < 0) begin
        failures++;
        $display("FAIL bench_restore_id id=%0d not live in model", rid);
      end else begin
        mtail = ckq[k].saved;
        while (ckq.size() > k + 1) void'(ckq.pop_back());
        next_id = (rid + 1) % NCK;
      end
    end else begin
      if (eaok) mtail = mtail + ac;
      if (ecok) begin
        ckq.push_back('{id: next_id, saved: mtail});
        next_id = (next_id + 1) % NCK;
      end
    end
    mhead = mhead + cc;
    if (crel) void'(ckq.pop_front());
    #1;
    check_state();
  endtask

  initial begin
    int ac, cc, room, rid;
    bit creq, crel, ren;

    // Fill from reset: tags 0..15, then full refuses one more.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(2, 0, 0, 0, 0, 0);
    chk("fill_full", 32'(bus.full), 32'd1);
    cycle(1, 0, 0, 0, 0, 0);
    // Full with simultaneous commit: alloc refused, then wraps to tags 0,1.
    cycle(2, 2, 0, 0, 0, 0);
    chk("full_commit_count", 32'(bus.count), 32'd14);
    cycle(2, 0, 0, 0, 0, 0);
    chk("wrap_count", 32'(bus.count), 32'd16);

    // Checkpoint together with allocation saves the post-allocation tail.
    do_reset();
    cycle(2, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(2, 0, 0, 0, 0, 0);
    cycle(2, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("restore_tail", 32'(bus.alloc_tag[0]), 32'd4);
    cycle(0, 0, 0, 1, 0, 0);

    // Three checkpoints, restore id 1, refill to full, release, wrap id to 0.
    do_reset();
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    chk("ckpt_full_set", 32'(bus.ckpt_full), 32'd1);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);

    // Restore beside alloc, checkpoint and commit: only commit survives.
    do_reset();
    cycle(2, 0, 0, 0, 0, 0);
    cycle(2, 0, 1, 0, 0, 0);
    cycle(2, 0, 0, 0, 0, 0);
    cycle(2, 1, 1, 0, 1, 0);
    chk("restore_commit_count", 32'(bus.count), 32'd3);

    // Random legal traffic; commits never pass the oldest checkpoint's tail.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        ac   = $urandom_range(0, AW);
        room = (ckq.size() > 0 ? ckq[0].saved : mtail) - mhead;
        cc   = $urandom_range(0, (room < CW) ? room : CW);
        creq = ($urandom_range(0, 2) == 0);
        crel = (ckq.size() > 0) && ($urandom_range(0, 4) == 0);
        ren  = (ckq.size() > 0) && ($urandom_range(0, 6) == 0);
        rid  = ren ? ckq[$urandom_range(0, ckq.size() - 1)].id : 0;
        cycle(ac, cc, creq, crel, ren, rid);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
